// File: rtl/controller_sseg_status_in.sv
// rtl/controller_sseg_status_in.sv - Avalon-MM status input port with rising-edge capture; IRQ mask enabled by SSEG_STATUS_IRQ_EN
module controller_sseg_status_in #(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [DATA_W-1:0] in_port,
    output logic [31:0]       readdata,
    output logic              irq
);
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_edge_cap;
    logic [31:0]       r_readdata;
    logic [DATA_W-1:0] w_irq_mask;
    logic [DATA_W-1:0] w_rise;
    logic [DATA_W-1:0] w_clr;
    logic [31:0]       w_rd_mux;
    logic              w_wr;
    logic              w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_rise         = r_s2 & ~r_prev;
    assign w_clr          = (w_wr && address == 2'd3) ? writedata[DATA_W-1:0] : '0;
    assign w_unused_wdata = &{1'b0, writedata[31:DATA_W]};

    // Synchronizer and history run unconditionally; only the bus side is gated by chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= in_port;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // A new edge wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_rise;
        end
    end

`ifdef SSEG_STATUS_IRQ_EN
    logic [DATA_W-1:0] r_irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_wr && address == 2'd2) begin
            r_irq_mask <= writedata[DATA_W-1:0];
        end
    end

    assign w_irq_mask = r_irq_mask;
    assign irq        = |(r_edge_cap & r_irq_mask);
`else
    assign w_irq_mask = '0;
    assign irq        = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[DATA_W-1:0] = r_s2;
            2'd2:    w_rd_mux[DATA_W-1:0] = w_irq_mask;
            2'd3:    w_rd_mux[DATA_W-1:0] = r_edge_cap;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
endmodule

// File: doc/controller_sseg_status_in.md
CONTROLLER_SSEG_STATUS_IN -- requirements
Module: controller_sseg_status_in

Interface
REQ-001 SHALL have parameter: DATA_W, default 7, width of in_port and of all per-bit registers.
REQ-002 SHALL have ports in this order:
- clk, input, 1, sole clock; all state on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, Avalon-MM word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- in_port, input, DATA_W, asynchronous status bits from the display side.
- readdata, output, 32, read data.
- irq, output, 1, active-high level interrupt.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL pass in_port through a two-flop synchronizer (s1, s2), then one history flop (prev <= s2).
REQ-005 SHALL detect rising edges per bit as s2 & ~prev. Falling edges SHALL be ignored.
REQ-006 SHALL use this address map:
- 0: DATA, read-only, value s2.
- 1: reserved, reads 0.
- 2: IRQMASK, read/write, bits [DATA_W-1:0].
- 3: EDGECAPTURE, read, write-1-to-clear.
REQ-007 SHALL perform a write when chipselect=1 and write_n=0. Writes to addresses 0 and 1 SHALL have no effect.
REQ-008 SHALL set each EDGECAPTURE bit on the clock where its edge is detected, and hold it until cleared.
REQ-009 SHALL clear EDGECAPTURE bit i on a write to address 3 with writedata[i]=1. Bits written 0 SHALL be unchanged.
REQ-010 SHALL give set priority when a clear and an edge on the same bit occur in the same cycle: the bit ends at 1.
REQ-011 SHALL register readdata every clock from the address-selected mux, giving read latency 1. Upper bits [31:DATA_W] SHALL be 0.
REQ-012 SHALL drive irq = OR of (EDGECAPTURE & IRQMASK), decoded combinationally from registers.
REQ-013 SHALL have latency: in_port rising before clk edge N -> s2=1 after edge N+1 -> EDGECAPTURE bit set after edge N+2.
REQ-014 SHALL require no chipselect for the synchronizer, history flop or edge detection; they run every cycle.

Reset
REQ-015 SHALL asynchronously clear to 0 on reset_n=0: s1, s2, prev, IRQMASK, EDGECAPTURE, readdata. irq SHALL therefore be 0.
REQ-016 SHALL capture an edge from an in_port bit held at 1 across reset release, three clocks after release, because prev and s2 reset to 0.
REQ-017 SHALL, when reset is asserted mid-operation, discard pending captures. No event SHALL survive reset.

Configuration
REQ-018 With macro SSEG_STATUS_IRQ_EN defined:
- IRQMASK register SHALL exist.
- irq SHALL follow REQ-012.
REQ-019 Without SSEG_STATUS_IRQ_EN:
- No IRQMASK register; address 2 SHALL read 0 and ignore writes.
- irq SHALL be tied to 0.
- EDGECAPTURE SHALL still operate.

Verification
REQ-020 After reset, in_port=7'h55: read address 0 two clocks later -> readdata=32'h55 one cycle after the read.
REQ-021 in_port bit3 0->1: after 3 clocks, read address 3 -> 32'h08. With IRQMASK=8'h08, irq=1. Write 32'h08 to address 3 -> EDGECAPTURE=0 and irq=0 next cycle.
REQ-022 Edge on bit0 in the same cycle as a write of 32'h01 to address 3 -> bit0 remains 1.
REQ-023 in_port falling 7'h7F->7'h00 -> EDGECAPTURE unchanged (0). IRQMASK=0 with captures present -> irq=0.
REQ-024 Assert reset_n with EDGECAPTURE=7'h7F and IRQMASK=7'h7F -> all registers 0 and irq=0 immediately, without a clock.
REQ-025 Build without SSEG_STATUS_IRQ_EN: write 32'h7F to address 2 and read back -> 0. Any edge -> irq stays 0.
